// File: rtl/coef_bank_seq_pkg.sv
// Shared constants, state encoding and default coefficient table
// for the biquad coefficient bank and its per-sample sequencer.
package coef_bank_seq_pkg;

    localparam int CANT_BITS_D = 25;
    localparam int N_MODES_D   = 4;
    localparam int MODE_W_D    = 2;
    localparam int N_SLOTS     = 6;

    localparam logic [2:0] SLOT_A0 = 3'd0;
    localparam logic [2:0] SLOT_B2 = 3'd5;

    localparam logic [31:0] Q_ONE = 32'h0000_4000;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Legacy datapath code: a0..a2 -> 0..2, b0..b2 -> 5..7
    function automatic logic [3:0] sel_code(input logic [2:0] slot);
        logic [3:0] code;
        code = {1'b0, slot};
        if (slot > 3'd2) begin
            code = code + 4'd2;
        end
        return code;
    endfunction

    // Reset contents: mode 0 is the shipped filter, the rest pass through
    function automatic logic [31:0] default_coef(input int mode, input int slot);
        logic [31:0] v;
        v = 32'h0;
        if (mode == 0) begin
            case (slot)
                0:       v = 32'h0000_4000;
                1:       v = 32'h01FF_9A2D;
                2:       v = 32'h01FF_D5A7;
                3:       v = 32'h0000_340B;
                4:       v = 32'h0000_6810;
                5:       v = 32'h0000_340B;
                default: v = 32'h0;
            endcase
        end else if (slot == 0 || slot == 3) begin
            v = Q_ONE;
        end
        return v;
    endfunction

endpackage

// File: rtl/coef_bank_regs.sv
// Coefficient storage: N_MODES x 6 registers, one write port,
// combinational read port addressed by (mode, slot).
module coef_bank_regs
    import coef_bank_seq_pkg::*;
#(
    parameter int cant_bits = CANT_BITS_D,
    parameter int N_MODES   = N_MODES_D,
    parameter int MODE_W    = MODE_W_D
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [MODE_W-1:0]    wr_mode,
    input  logic [2:0]           wr_slot,
    input  logic [cant_bits-1:0] wr_data,
    input  logic [MODE_W-1:0]    rd_mode,
    input  logic [2:0]           rd_slot,
    output logic [cant_bits-1:0] rd_data
);

    logic [cant_bits-1:0] mem [N_MODES][N_SLOTS];

    // Reload defaults on reset; commit in-range writes only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < N_MODES; m++) begin
                for (int s = 0; s < N_SLOTS; s++) begin
                    mem[m][s] <= cant_bits'(default_coef(m, s));
                end
            end
        end else if (wr_en && wr_slot <= SLOT_B2) begin
            mem[wr_mode][wr_slot] <= wr_data;
        end
    end

    assign rd_data = mem[rd_mode][rd_slot];

endmodule

// File: rtl/coef_bank_seq.sv
// Per-sample coefficient sequencer: streams the six coefficients of
// the selected mode, one per accepted beat, and arbitrates writes.
module coef_bank_seq
    import coef_bank_seq_pkg::*;
#(
    parameter int cant_bits = CANT_BITS_D,
    parameter int N_MODES   = N_MODES_D,
    parameter int MODE_W    = MODE_W_D
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [MODE_W-1:0]    mode_sel,
    input  logic                 start,
    input  logic                 cte_ready,
    output logic                 cte_valid,
    output logic [cant_bits-1:0] cte,
    output logic [3:0]           sel_cte,
    output logic                 cte_last,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 wr_en,
    input  logic [MODE_W-1:0]    wr_mode,
    input  logic [2:0]           wr_slot,
    input  logic [cant_bits-1:0] wr_data,
    output logic                 wr_ready,
    output logic                 wr_err
);

    state_t               state, state_nx;
    logic [MODE_W-1:0]    act_mode, act_nx;
    logic [2:0]           slot, slot_nx;
    logic [cant_bits-1:0] rd_data, cte_nx;
    logic [3:0]           sel_nx;
    logic                 valid_nx, last_nx, busy_nx;
    logic                 overrun_nx, wr_err_nx;
    logic                 load, accept, wr_acc;

    assign accept = cte_valid && cte_ready;

    // Writes into the streaming (or about-to-stream) set are held off
    assign wr_ready = !((busy && wr_mode == act_mode) ||
                        (start && !busy && wr_mode == mode_sel));
    assign wr_acc   = wr_en && wr_ready;

    coef_bank_regs #(
        .cant_bits (cant_bits),
        .N_MODES   (N_MODES),
        .MODE_W    (MODE_W)
    ) u_regs (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_acc),
        .wr_mode (wr_mode),
        .wr_slot (wr_slot),
        .wr_data (wr_data),
        .rd_mode (act_nx),
        .rd_slot (slot_nx),
        .rd_data (rd_data)
    );

    // Next-state, next beat and status pulses
    always_comb begin
        state_nx   = state;
        act_nx     = act_mode;
        slot_nx    = slot;
        valid_nx   = cte_valid;
        cte_nx     = cte;
        sel_nx     = sel_cte;
        last_nx    = cte_last;
        load       = 1'b0;
        overrun_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    act_nx   = mode_sel;
                    slot_nx  = SLOT_A0;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                overrun_nx = start && !(accept && cte_last);
                if (accept) begin
                    if (slot == SLOT_B2) begin
                        if (start) begin
                            load    = 1'b1;
                            act_nx  = mode_sel;
                            slot_nx = SLOT_A0;
                        end else begin
                            state_nx = IDLE;
                            valid_nx = 1'b0;
                            cte_nx   = '0;
                            sel_nx   = 4'd0;
                            last_nx  = 1'b0;
                        end
                    end else begin
                        load    = 1'b1;
                        slot_nx = slot + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (load) begin
            valid_nx = 1'b1;
            cte_nx   = rd_data;
            sel_nx   = sel_code(slot_nx);
            last_nx  = (slot_nx == SLOT_B2);
        end
        busy_nx   = (state_nx == STREAM);
        wr_err_nx = wr_acc && (wr_slot > SLOT_B2);
    end

    // State, beat and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            act_mode  <= '0;
            slot      <= SLOT_A0;
            cte_valid <= 1'b0;
            cte       <= '0;
            sel_cte   <= 4'd0;
            cte_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state     <= state_nx;
            act_mode  <= act_nx;
            slot      <= slot_nx;
            cte_valid <= valid_nx;
            cte       <= cte_nx;
            sel_cte   <= sel_nx;
            cte_last  <= last_nx;
            busy      <= busy_nx;
            overrun   <= overrun_nx;
            wr_err    <= wr_err_nx;
        end
    end

endmodule

// File: tb/tb_coef_bank_seq.sv
// Bench for coef_bank_seq: queue-based beat model, per-cycle compare,
// directed literal scenarios and a randomized phase.
module tb_coef_bank_seq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  mode_sel;
    logic        start;
    logic        cte_ready;
    logic        cte_valid;
    logic [24:0] cte;
    logic [3:0]  sel_cte;
    logic        cte_last;
    logic        busy;
    logic        overrun;
    logic        wr_en;
    logic [1:0]  wr_mode;
    logic [2:0]  wr_slot;
    logic [24:0] wr_data;
    logic        wr_ready;
    logic        wr_err;

    coef_bank_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode_sel  (mode_sel),
        .start     (start),
        .cte_ready (cte_ready),
        .cte_valid (cte_valid),
        .cte       (cte),
        .sel_cte   (sel_cte),
        .cte_last  (cte_last),
        .busy      (busy),
        .overrun   (overrun),
        .wr_en     (wr_en),
        .wr_mode   (wr_mode),
        .wr_slot   (wr_slot),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .wr_err    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      nm, act, exp, $time);
    endtask

    logic [24:0] lit_v [6] = '{25'h4000, 25'h1FF9A2D, 25'h1FFD5A7,
                               25'h340B, 25'h6810, 25'h340B};
    logic [3:0]  lit_c [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7};
    logic [24:0] pt_v  [6] = '{25'h4000, 25'h0, 25'h0,
                               25'h4000, 25'h0, 25'h0};

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [24:0] v;
        logic [3:0]  c;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic [24:0] mm [4][6];
    logic [1:0]  m_act;
    logic        m_ovr, m_werr;
    logic        b_pre, b_acc, b_lastacc, b_start, b_wr;
    beat_t       nb_t;

    function automatic logic [24:0] dflt(input int m, input int s);
        if (m == 0) return lit_v[s];
        return pt_v[s];
    endfunction

    function automatic logic exp_ready();
        logic bz;
        bz = (q.size() > 0);
        return !((bz && wr_mode == m_act) ||
                 (start && !bz && wr_mode == mode_sel));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            for (int m = 0; m < 4; m++)
                for (int s = 0; s < 6; s++)
                    mm[m][s] = dflt(m, s);
            m_act  = 2'd0;
            m_ovr  = 1'b0;
            m_werr = 1'b0;
        end else begin
            b_pre     = (q.size() > 0);
            b_acc     = b_pre && cte_ready;
            b_lastacc = b_acc && (q.size() == 1);
            b_start   = start && (!b_pre || b_lastacc);
            b_wr      = wr_en && exp_ready();
            m_ovr     = start && !b_start;
            m_werr    = b_wr && (wr_slot > 3'd5);
            if (b_acc) void'(q.pop_front());
            if (b_start) begin
                m_act = mode_sel;
                for (int s = 0; s < 6; s++) begin
                    nb_t.v    = mm[mode_sel][s];
                    nb_t.c    = lit_c[s];
                    nb_t.last = (s == 5);
                    q.push_back(nb_t);
                end
            end
            if (b_wr && wr_slot <= 3'd5)
                mm[wr_mode][wr_slot] = wr_data;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("valid",    32'(cte_valid), 32'(q.size() > 0));
        chk("busy",     32'(busy),      32'(q.size() > 0));
        chk("overrun",  32'(overrun),   32'(m_ovr));
        chk("wr_err",   32'(wr_err),    32'(m_werr));
        chk("wr_ready", 32'(wr_ready),  32'(exp_ready()));
        if (!reset_n) begin
            chk("rst_cte", 32'(cte),     32'(0));
            chk("rst_sel", 32'(sel_cte), 32'(0));
        end else if (q.size() > 0) begin
            chk("cte",  32'(cte),      32'(q[0].v));
            chk("sel",  32'(sel_cte),  32'(q[0].c));
            chk("last", 32'(cte_last), 32'(q[0].last));
        end
    end

    // ---------------- stimulus ----------------
    logic [24:0] got  [8];
    logic [3:0]  gotc [8];
    int n, nb;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input logic [1:0] m);
        mode_sel  = m;
        cte_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            got[i]  = cte;
            gotc[i] = sel_cte;
            chk("c_last", 32'(cte_last), 32'(i == 5));
        end
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        mode_sel  = 2'd0;
        start     = 1'b0;
        cte_ready = 1'b0;
        wr_en     = 1'b0;
        wr_mode   = 2'd0;
        wr_slot   = 3'd0;
        wr_data   = 25'd0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // default mode 0 stream, ready tied high
        collect(2'd0);
        for (int i = 0; i < 6; i++) begin
            chk("d1_cte", 32'(got[i]),  32'(lit_v[i]));
            chk("d1_sel", 32'(gotc[i]), 32'(lit_c[i]));
        end

        // ready toggling 1,0,0,1
        mode_sel = 2'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            cte_ready = pat[k % 4];
            @(negedge clk);
            if (cte_valid && cte_ready) begin
                if (nb < 8) got[nb] = cte;
                nb++;
            end
            tick();
        end
        chk("d2_count", 32'(nb), 32'(6));
        for (int i = 0; i < 6; i++)
            chk("d2_cte", 32'(got[i]), 32'(lit_v[i]));

        // idle write then stream mode 1
        wr_en   = 1'b1;
        wr_mode = 2'd1;
        wr_slot = 3'd4;
        wr_data = 25'h1234;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("d3_werr", 32'(wr_err), 32'(0));
        tick();
        collect(2'd1);
        chk("d3_s0", 32'(got[0]), 32'h4000);
        chk("d3_s3", 32'(got[3]), 32'h4000);
        chk("d3_s4", 32'(got[4]), 32'h1234);
        chk("d3_s5", 32'(got[5]), 32'h0);

        // mid-stream writes: other mode accepted, active mode held
        mode_sel  = 2'd0;
        cte_ready = 1'b1;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_mode = 2'd2;
        wr_slot = 3'd1;
        wr_data = 25'h0ABCDE;
        #1 chk("d4_other", 32'(wr_ready), 32'(1));
        tick();
        wr_mode = 2'd0;
        wr_slot = 3'd2;
        wr_data = 25'h1555;
        #1 chk("d4_block", 32'(wr_ready), 32'(0));
        n = 0;
        while (!wr_ready && n < 20) begin
            tick();
            n++;
        end
        chk("d4_unblock", 32'(wr_ready), 32'(1));
        chk("d4_wait", 32'(n), 32'(5));
        tick();
        wr_en = 1'b0;
        collect(2'd0);
        chk("d4_m0s2", 32'(got[2]), 32'h1555);
        collect(2'd2);
        chk("d4_m2s1", 32'(got[1]), 32'h0ABCDE);

        // overrun, then seamless back-to-back
        mode_sel = 2'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("d5_ovr", 32'(overrun), 32'(1));
        tick();
        n = 0;
        while (!cte_last && n < 10) begin
            tick();
            n++;
        end
        chk("d5_lastseen", 32'(cte_last), 32'(1));
        mode_sel = 2'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("d5_b2b_v",   32'(cte_valid), 32'(1));
        chk("d5_b2b_cte", 32'(cte),       32'h4000);
        chk("d5_b2b_sel", 32'(sel_cte),   32'(0));
        chk("d5_b2b_ovr", 32'(overrun),   32'(0));
        repeat (8) tick();

        // out-of-range slot write
        wr_en   = 1'b1;
        wr_mode = 2'd3;
        wr_slot = 3'd6;
        wr_data = 25'h1FFFFFF;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("d6_werr", 32'(wr_err), 32'(1));
        tick();
        @(negedge clk);
        chk("d6_werr_end", 32'(wr_err), 32'(0));
        tick();
        collect(2'd3);
        for (int i = 0; i < 6; i++)
            chk("d6_m3", 32'(got[i]), 32'(pt_v[i]));

        // reset mid-stream
        mode_sel = 2'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #1 reset_n = 1'b0;
        #1;
        chk("d7_valid", 32'(cte_valid), 32'(0));
        chk("d7_busy",  32'(busy),      32'(0));
        chk("d7_cte",   32'(cte),       32'(0));
        chk("d7_last",  32'(cte_last),  32'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        collect(2'd1);
        chk("d7_m1s0", 32'(got[0]), 32'h4000);
        chk("d7_m1s4", 32'(got[4]), 32'h0);

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            start     = ($urandom_range(0, 5) == 0);
            mode_sel  = 2'($urandom);
            cte_ready = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_mode   = 2'($urandom);
            if (start && wr_mode == mode_sel) wr_mode = wr_mode + 2'd1;
            wr_slot = 3'($urandom);
            wr_data = 25'($urandom);
            tick();
        end
        start     = 1'b0;
        wr_en     = 1'b0;
        cte_ready = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
